max7219_display_sequencer: RTL and testbench
============================================

# max7219_display_sequencer

Controller that sequences the serial 7-segment driver link (LOAD/DOUT/SCK) of the desk clock. After reset it issues the driver's configuration words, then on each update request writes the current BCD digits as one burst of 16-bit frames. Sits between the time-keeping core's digit outputs and the top-level serial pins; sole owner of the serial link.

## Interface
- `CLK_DIV`, 2: i_clk cycles per SCK half-period; legal range 1..255.
- `NUM_DIGITS`, 4: digits driven; legal range 1..8.
- `INTENSITY`, 4'h8: brightness code written during init.
- `i_clk` in 1: single clock; all state changes on rising edge.
- `i_reset_n` in 1: reset, synchronous, active-low.
- `i_en` in 1: gates the start of new frames; a frame in progress always completes.
- `i_digits` in 4*NUM_DIGITS: BCD digits, digit 0 in bits [3:0].
- `i_update` in 1: request to refresh the display; level or strobe, sampled each cycle.
- `o_busy` out 1: high while the init or update sequence is active.
- `o_serial_load` out 1: driver CS/LOAD; low during a frame, rising edge latches the word.
- `o_serial_dout` out 1: serial data, MSB first.
- `o_serial_clk` out 1: SCK; the driver samples DOUT on its rising edge.

## Operation
- Frame format: {4'h0, addr[3:0], data[7:0]}, bit 15 first.
- States: `INIT`, `IDLE`, `UPDATE`. Each state has an index counter and a frame-start/frame-done handshake with the shifter.
- `INIT` is entered on reset release. It sends 5 frames in order:
  - 0x0C01: normal operation.
  - 0x0B, NUM_DIGITS-1: scan limit.
  - 0x09, (1<<NUM_DIGITS)-1: code-B decode.
  - 0x0A, INTENSITY.
  - 0x0F00: display test off.
- `INIT` then goes to `UPDATE` (one forced refresh), then to `IDLE`.
- `UPDATE`: i_digits is snapshotted into a register on entry. It sends frames addr = k+1, data = {4'h0, digit k} for k = 0..NUM_DIGITS-1 in ascending order.
- `IDLE` goes to `UPDATE` when the pending flag is set or i_update is high, and i_en is high.
- Pending flag:
  - Set by i_update sampled high while o_busy is high; cleared on entry to `UPDATE`.
  - Multiple requests during one sequence collapse into one refresh.
  - That refresh uses the digits as they are at its own start, not at request time.
- i_en low: no frame starts. The state index and pending flag hold. Sequencing resumes exactly where it stopped once i_en returns high.
- o_busy is high in `INIT` and `UPDATE`, including while they are stalled by i_en. It is low only in `IDLE`.

## Timing
- Reset values: o_serial_load=1, o_serial_clk=0, o_serial_dout=0, o_busy=1 (init pending), pending=0, state=`INIT` with index 0.
- Reset asserted mid-frame: at the next edge LOAD=1 and SCK=0. The partial word is discarded and init restarts from frame 0.
- Frame start:
  - LOAD falls on the edge after the start decision.
  - DOUT=bit15 and SCK=0 for CLK_DIV cycles.
- Each bit: SCK high for CLK_DIV cycles, then low for CLK_DIV cycles. DOUT advances to the next bit on the SCK falling edge, so it is stable across every rising edge.
- LOAD rises 33*CLK_DIV cycles after falling, with SCK low. LOAD stays high at least CLK_DIV cycles before the next frame.
- Frame-to-frame period: 34*CLK_DIV cycles. Default: 68 cycles.
- Sequence lengths:
  - Init: 5 frames, 340 cycles at default.
  - Update: NUM_DIGITS frames, 272 cycles at default.
- Latency: i_update high in `IDLE` with i_en=1 → LOAD low 2 edges later (state change, then frame start).
- o_busy falls on the edge where LOAD rises for the last frame of a sequence, unless the pending flag is set. In that case o_busy stays high and the next `UPDATE` begins.

## Configuration
- `DISPLAY_TEST_EN` defined:
  - Adds input `i_test` (1 bit).
  - A change of i_test seen in `IDLE` sends a single frame 0x0F, {7'h0, i_test} (display test on/off).
  - The same change seen while busy is queued like an update. It is serviced before any pending refresh.
- `DISPLAY_TEST_EN` undefined: no port. Display test is only ever written as 0x0F00 during init.

## Structure
- Package `display_seq_pkg`:
  - Register address constants: REG_DIGIT0, REG_DECODE, REG_INTENSITY, REG_SCANLIMIT, REG_SHUTDOWN, REG_TEST.
  - State enum.
  - Frame-width constant (16).
- One sub-module, `serial_word_shifter`. It:
  - takes a 16-bit word and a start pulse;
  - handles the CLK_DIV divider, bit counter, LOAD/SCK/DOUT generation and the inter-frame gap;
  - returns a one-cycle done pulse.
- The sequencer FSM, snapshot register and pending flag live in the top block.

## Test plan
- Reset release, i_en=1, defaults → 9 frames decoded from pins: 0C01, 0B03, 090F, 0A08, 0F00, 0100|d0 ... 0400|d3. o_busy falls at the end of the 9th frame; every frame period is 68 cycles.
- In IDLE with i_digits=16'h1234, pulse i_update → LOAD low 2 edges later. Frames 0104, 0203, 0302, 0401.
- During an update, pulse i_update 3 times and change i_digits to 16'h0959 → exactly one extra burst, carrying 0109, 0205, 0309, 0400.
- Assert i_reset_n low at bit 7 of a digit frame → next edge LOAD=1, SCK=0, o_busy=1. After release the full init sequence repeats from 0C01.
- Drop i_en during init frame 2 → frame 2 completes and no LOAD falls while i_en is low. On restore, frame 3 (0A08) is sent next.
- With `DISPLAY_TEST_EN`, toggle i_test 0→1 in IDLE → a single frame 0F01. Toggle it again during an update → 0F00 is sent right after the update's last frame.

Source files
------------

// File: rtl/max7219_display_sequencer_pkg.sv
// Shared constants for the MAX7219-style display sequencer: driver register
// addresses, sequencer states and the 16-bit frame layout.
package display_seq_pkg;

    localparam int FRAME_W     = 16;
    localparam int INIT_FRAMES = 5;

    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    // ST_TEST is only reachable when the display-test feature is built in
    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_UPDATE,
        ST_TEST
    } seq_state_e;

    function automatic logic [FRAME_W-1:0] mk_frame(input logic [3:0] addr,
                                                    input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

endpackage

// File: rtl/max7219_display_sequencer_shifter.sv
// serial_word_shifter: sends one 16-bit word MSB first on LOAD/SCK/DOUT,
// including the trailing LOAD-high gap, and pulses o_done as LOAD rises.
import display_seq_pkg::*;

module serial_word_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_word,
    output logic               o_ready,
    output logic               o_done,
    output logic               o_load,
    output logic               o_sck,
    output logic               o_dout
);

    // Half-period phases: 0 = lead-in low, 1..32 = SCK high/low per bit,
    // 33 = LOAD-high gap before the next frame may start.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] PH_TAIL  = 6'd32;
    localparam logic [5:0] PH_GAP   = 6'd33;

    logic               active_q, active_d;
    logic [5:0]         ph_q, ph_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic               load_q, load_d;
    logic               sck_q, sck_d;
    logic               dout_q, dout_d;
    logic               tick, accept;
    logic [5:0]         ph_nx;

    assign tick    = active_q && (cnt_q == DIV_LAST);
    assign o_ready = !active_q || (tick && (ph_q == PH_GAP));
    assign o_done  = tick && (ph_q == PH_TAIL);
    assign accept  = i_start && o_ready;
    assign ph_nx   = ph_q + 6'd1;

    always_comb begin
        active_d = active_q;
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        load_d   = load_q;
        sck_d    = sck_q;
        dout_d   = dout_q;
        if (accept) begin
            active_d = 1'b1;
            ph_d     = '0;
            cnt_d    = '0;
            sh_d     = i_word;
            load_d   = 1'b0;
            sck_d    = 1'b0;
            dout_d   = i_word[FRAME_W-1];
        end else if (active_q) begin
            if (!tick) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = '0;
                if (ph_q == PH_GAP) begin
                    active_d = 1'b0;
                end else begin
                    ph_d = ph_nx;
                    if (ph_nx == PH_GAP) begin
                        load_d = 1'b1;
                        sck_d  = 1'b0;
                        dout_d = 1'b0;
                    end else if (ph_nx[0]) begin
                        sck_d = 1'b1;
                    end else begin
                        // DOUT only moves on the falling edge; none after bit 0
                        sck_d = 1'b0;
                        if (ph_nx != PH_TAIL) begin
                            dout_d = sh_q[FRAME_W-2];
                            sh_d   = {sh_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            active_q <= 1'b0;
            ph_q     <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            load_q   <= 1'b1;
            sck_q    <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            load_q   <= load_d;
            sck_q    <= sck_d;
            dout_q   <= dout_d;
        end
    end

    assign o_load = load_q;
    assign o_sck  = sck_q;
    assign o_dout = dout_q;

endmodule

// File: rtl/max7219_display_sequencer.sv
// Display sequencer: driver init, then digit bursts on request over the serial link.
// Optional DISPLAY_TEST_EN adds i_test, forwarded as single display-test frames.
import display_seq_pkg::*;

module max7219_display_sequencer #(
    parameter int         CLK_DIV    = 2,
    parameter int         NUM_DIGITS = 4,
    parameter logic [3:0] INTENSITY  = 4'h8
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_en,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic                    i_update,
`ifdef DISPLAY_TEST_EN
    input  logic                    i_test,
`endif
    output logic                    o_busy,
    output logic                    o_serial_load,
    output logic                    o_serial_dout,
    output logic                    o_serial_clk
);

    localparam logic [2:0] LAST_INIT  = 3'(INIT_FRAMES - 1);
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    seq_state_e              state_q;
    logic [2:0]              idx_q;
    logic                    pend_q;
    logic                    busy_q;
    logic [4*NUM_DIGITS-1:0] snap_q;
`ifdef DISPLAY_TEST_EN
    logic                    test_q;
`endif

    logic [FRAME_W-1:0] word;
    logic [31:0]        snap_pad;
    logic [3:0]         digit;
    logic               sh_ready, sh_done, sh_start;
    logic               last_frame, init_end, enter;
    seq_state_e         seq_next, tgt;

    assign snap_pad = 32'(snap_q);
    assign digit    = snap_pad[{idx_q, 2'b00} +: 4];

    always_comb begin
        word = '0;
        case (state_q)
            ST_INIT: begin
                case (idx_q)
                    3'd0:    word = mk_frame(REG_SHUTDOWN, 8'h01);
                    3'd1:    word = mk_frame(REG_SCANLIMIT, 8'(NUM_DIGITS - 1));
                    3'd2:    word = mk_frame(REG_DECODE, 8'((1 << NUM_DIGITS) - 1));
                    3'd3:    word = mk_frame(REG_INTENSITY, {4'h0, INTENSITY});
                    default: word = mk_frame(REG_TEST, 8'h00);
                endcase
            end
            ST_UPDATE: word = mk_frame(REG_DIGIT0 + {1'b0, idx_q}, {4'h0, digit});
`ifdef DISPLAY_TEST_EN
            ST_TEST:   word = mk_frame(REG_TEST, {7'h0, test_q});
`endif
            default:   word = '0;
        endcase
    end

    // Where to go once a sequence ends; a test change outranks a refresh
    always_comb begin
        seq_next = ST_IDLE;
        if (pend_q || i_update) seq_next = ST_UPDATE;
`ifdef DISPLAY_TEST_EN
        if (i_test != test_q) seq_next = ST_TEST;
`endif
    end

    assign last_frame = ((state_q == ST_INIT)   && (idx_q == LAST_INIT))  ||
                        ((state_q == ST_UPDATE) && (idx_q == LAST_DIGIT)) ||
                        (state_q == ST_TEST);
    assign init_end   = sh_done && (state_q == ST_INIT) && (idx_q == LAST_INIT);
    assign enter      = (sh_done && last_frame) ||
                        ((state_q == ST_IDLE) && i_en && (seq_next != ST_IDLE));
    assign tgt        = init_end ? ST_UPDATE : seq_next;
    assign sh_start   = (state_q != ST_IDLE) && i_en && sh_ready;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            snap_q  <= '0;
`ifdef DISPLAY_TEST_EN
            test_q  <= 1'b0;
`endif
        end else begin
            if (busy_q && i_update) pend_q <= 1'b1;
            if (enter) begin
                state_q <= tgt;
                idx_q   <= '0;
                busy_q  <= (tgt != ST_IDLE);
                if (tgt == ST_UPDATE) begin
                    snap_q <= i_digits;
                    pend_q <= 1'b0;
                end
`ifdef DISPLAY_TEST_EN
                if (tgt == ST_TEST) test_q <= i_test;
`endif
            end else if (sh_done) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    serial_word_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (sh_start),
        .i_word    (word),
        .o_ready   (sh_ready),
        .o_done    (sh_done),
        .o_load    (o_serial_load),
        .o_sck     (o_serial_clk),
        .o_dout    (o_serial_dout)
    );

    assign o_busy = busy_q;

endmodule

// File: tb/tb_max7219_display_sequencer.sv
// Bench for max7219_display_sequencer: frames are decoded from the pins and
// matched against a scoreboard of expected words.
module tb_max7219_display_sequencer;

    localparam int CD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        upd = 1'b0;
    logic [15:0] digits = 16'h5678;
`ifdef DISPLAY_TEST_EN
    logic        tst = 1'b0;
`endif
    logic        busy, load, sck, dout;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    int          falls[$];
    int          last_rise = 0;
    int          fall_cyc = 0;
    int          nbits = 0;
    logic        in_frame = 1'b0;
    logic [15:0] sh = '0;
    logic        p_load = 1'b1;
    logic        p_sck = 1'b0;

    always #5 clk = ~clk;

    max7219_display_sequencer dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_en          (en),
        .i_digits      (digits),
        .i_update      (upd),
`ifdef DISPLAY_TEST_EN
        .i_test        (tst),
`endif
        .o_busy        (busy),
        .o_serial_load (load),
        .o_serial_dout (dout),
        .o_serial_clk  (sck)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pin-level frame decoder
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (p_load && !load) begin
                in_frame = 1'b1;
                nbits    = 0;
                fall_cyc = cyc;
                falls.push_back(cyc);
            end
            if (in_frame && !p_sck && sck) begin
                sh = {sh[14:0], dout};
                nbits++;
            end
            if (!p_load && load && in_frame) begin
                in_frame  = 1'b0;
                last_rise = cyc;
                chk("frame_bits", nbits, 16);
                chk("load_low_len", cyc - fall_cyc, 33 * CD);
                chk("sck_at_load_rise", sck, 1'b0);
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("frame_word", sh, exp_q.pop_front());
            end
        end
        p_load = load;
        p_sck  = sck;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_update();
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic push_digits(input logic [15:0] d);
        for (int k = 0; k < 4; k++) exp_q.push_back({4'h0, 4'(k + 1), 4'h0, d[4*k +: 4]});
    endtask

    task automatic push_init(input logic [15:0] d);
        exp_q.push_back(16'h0C01);
        exp_q.push_back(16'h0B03);
        exp_q.push_back(16'h090F);
        exp_q.push_back(16'h0A08);
        exp_q.push_back(16'h0F00);
        push_digits(d);
    endtask

    initial begin
        int nf;
        int t0;
        int n;

        // Reset state
        cycles(3);
        chk("rst_load", load, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_dout", dout, 1'b0);
        chk("rst_busy", busy, 1'b1);

        // Init + forced refresh after reset release
        push_init(16'h5678);
        t0 = cyc;
        rst_n = 1'b1;
        cycles(1);
        chk("init_busy", busy, 1'b1);
        wait_idle("init_done", 1500);
        chk("busy_fall_at_load_rise", cyc, last_rise);
        chk("init_sb_empty", exp_q.size(), 0);
        chk("init_nframes", falls.size(), 9);
        if (falls.size() > 0) chk("init_first_fall", falls[0] - t0, 1);
        for (int i = 1; i < falls.size(); i++) chk("init_period", falls[i] - falls[i-1], 34 * CD);

        // Single update from IDLE: latency and digit order
        cycles(5);
        digits = 16'h1234;
        push_digits(16'h1234);
        nf = falls.size();
        t0 = cyc;
        pulse_update();
        chk("upd_busy", busy, 1'b1);
        wait_idle("upd_done", 1000);
        chk("upd_latency", (falls.size() > nf) ? falls[nf] - t0 : -1, 2);
        chk("upd_nframes", falls.size() - nf, 4);
        chk("upd_sb_empty", exp_q.size(), 0);

        // Requests during a burst collapse into one refresh with fresh digits
        cycles(5);
        nf = falls.size();
        push_digits(16'h1234);
        push_digits(16'h0959);
        pulse_update();
        cycles(20);
        pulse_update();
        cycles(5);
        pulse_update();
        digits = 16'h0959;
        cycles(5);
        pulse_update();
        wait_idle("coll_done", 2000);
        chk("coll_nframes", falls.size() - nf, 8);
        chk("coll_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a digit frame
        cycles(5);
        pulse_update();
        n = 0;
        while (!(in_frame && nbits == 9) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach", nbits, 9);
        rst_n = 1'b0;
        cycles(1);
        chk("rst_mid_load", load, 1'b1);
        chk("rst_mid_sck", sck, 1'b0);
        chk("rst_mid_busy", busy, 1'b1);
        cycles(1);
        push_init(16'h0959);
        nf = falls.size();
        rst_n = 1'b1;
        cycles(1);
        wait_idle("rst_reinit_done", 1500);
        chk("rst_reinit_nframes", falls.size() - nf, 9);
        chk("rst_reinit_sb_empty", exp_q.size(), 0);

        // i_en dropped during init frame 2
        cycles(3);
        rst_n = 1'b0;
        cycles(2);
        push_init(16'h0959);
        nf = falls.size();
        rst_n = 1'b1;
        n = 0;
        while (falls.size() < nf + 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        chk("en_reach", falls.size() - nf, 3);
        cycles(300);
        chk("en_hold_frames", falls.size() - nf, 3);
        chk("en_hold_busy", busy, 1'b1);
        chk("en_hold_sb", exp_q.size(), 6);
        en = 1'b1;
        wait_idle("en_done", 1500);
        chk("en_nframes", falls.size() - nf, 9);
        chk("en_sb_empty", exp_q.size(), 0);

`ifdef DISPLAY_TEST_EN
        // Display-test toggles: in IDLE, then queued behind an update
        cycles(5);
        nf = falls.size();
        exp_q.push_back(16'h0F01);
        tst = 1'b1;
        cycles(1);
        chk("test_busy", busy, 1'b1);
        wait_idle("test_on_done", 500);
        chk("test_on_nframes", falls.size() - nf, 1);
        cycles(5);
        nf = falls.size();
        push_digits(16'h0959);
        exp_q.push_back(16'h0F00);
        pulse_update();
        cycles(30);
        tst = 1'b0;
        wait_idle("test_off_done", 1500);
        chk("test_off_nframes", falls.size() - nf, 5);
        chk("test_off_sb_empty", exp_q.size(), 0);
`endif

        cycles(5);
        chk("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
